// File: rtl/morse_tx_sequencer.sv
// Morse transmit engine: character FIFO feeding a cycle-exact keying FSM.
// oLED/oCharDone are registered views of the FSM and trail the state by one cycle.
module morse_tx_sequencer #(
  parameter int UNIT_CYCLES    = 12_500_000,
  parameter int FIFO_DEPTH     = 8,
  parameter int DASH_UNITS     = 3,
  parameter int CHAR_GAP_UNITS = 3,
  parameter int WORD_GAP_UNITS = 7
) (
  input  logic                          iCLK,
  input  logic                          iRST,
  input  logic                          iEnable,
  input  logic                          iClear,
  input  logic [4:0]                    iChar,
  input  logic                          iValid,
  output logic                          oReady,
  output logic [$clog2(FIFO_DEPTH):0]   oLevel,
  output logic                          oLED,
  output logic                          oBusy,
  output logic [4:0]                    oCurChar,
  output logic                          oCharDone
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int LW    = PW + 1;
  localparam int WG_U  = WORD_GAP_UNITS - CHAR_GAP_UNITS;
  localparam int M1_U  = (DASH_UNITS > CHAR_GAP_UNITS) ? DASH_UNITS : CHAR_GAP_UNITS;
  localparam int MAX_U = (M1_U > WG_U) ? M1_U : WG_U;
  localparam int TW    = $clog2(MAX_U * UNIT_CYCLES);

  localparam logic [TW-1:0] T_DOT  = TW'(UNIT_CYCLES - 1);
  localparam logic [TW-1:0] T_DASH = TW'(DASH_UNITS * UNIT_CYCLES - 1);
  localparam logic [TW-1:0] T_CG   = TW'(CHAR_GAP_UNITS * UNIT_CYCLES - 1);
  localparam logic [TW-1:0] T_WG   = TW'(WG_U * UNIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MARK, S_EL_GAP, S_CHAR_GAP, S_WORD_GAP
  } state_t;

  // {len[2:0], pattern[3:0]} with pattern MSB-first, 1 = dash
  function automatic logic [6:0] morse_lut(input logic [4:0] c);
    case (c)
      5'd0:  morse_lut = {3'd2, 4'b0100};
      5'd1:  morse_lut = {3'd4, 4'b1000};
      5'd2:  morse_lut = {3'd4, 4'b1010};
      5'd3:  morse_lut = {3'd3, 4'b1000};
      5'd4:  morse_lut = {3'd1, 4'b0000};
      5'd5:  morse_lut = {3'd4, 4'b0010};
      5'd6:  morse_lut = {3'd3, 4'b1100};
      5'd7:  morse_lut = {3'd4, 4'b0000};
      5'd8:  morse_lut = {3'd2, 4'b0000};
      5'd9:  morse_lut = {3'd4, 4'b0111};
      5'd10: morse_lut = {3'd3, 4'b1010};
      5'd11: morse_lut = {3'd4, 4'b0100};
      5'd12: morse_lut = {3'd2, 4'b1100};
      5'd13: morse_lut = {3'd2, 4'b1000};
      5'd14: morse_lut = {3'd3, 4'b1110};
      5'd15: morse_lut = {3'd4, 4'b0110};
      5'd16: morse_lut = {3'd4, 4'b1101};
      5'd17: morse_lut = {3'd3, 4'b0100};
      5'd18: morse_lut = {3'd3, 4'b0000};
      5'd19: morse_lut = {3'd1, 4'b1000};
      5'd20: morse_lut = {3'd3, 4'b0010};
      5'd21: morse_lut = {3'd4, 4'b0001};
      5'd22: morse_lut = {3'd3, 4'b0110};
      5'd23: morse_lut = {3'd4, 4'b1001};
      5'd24: morse_lut = {3'd4, 4'b1011};
      5'd25: morse_lut = {3'd4, 4'b1100};
      default: morse_lut = 7'd0;
    endcase
  endfunction

  logic [4:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [LW-1:0] lvl_q;
  logic          push, pop;
  logic [4:0]    head;

  assign oReady = (lvl_q != LW'(FIFO_DEPTH));
  assign oLevel = lvl_q;
  assign head   = mem_q[rp_q];
  assign push   = iValid & oReady & ~iClear;

  always_ff @(posedge iCLK) begin
    if (push) mem_q[wp_q] <= iChar;
  end

  always_ff @(posedge iCLK) begin
    if (iRST || iClear) begin
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + PW'(1);
      if (pop)  rp_q <= rp_q + PW'(1);
      case ({push, pop})
        2'b10:   lvl_q <= lvl_q + LW'(1);
        2'b01:   lvl_q <= lvl_q - LW'(1);
        default: lvl_q <= lvl_q;
      endcase
    end
  end

  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [4:0]    cur_q;
  logic [2:0]    len_q;
  logic [3:0]    pat_q;
  logic [1:0]    el_q;
  logic          led_q, led_d, done_q, done_d;
  logic          dash;

  assign dash = pat_q[2'd3 - el_q];

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    done_d  = 1'b0;
    // Clear or disable abandons the current character without a done pulse
    if (iClear || !iEnable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (lvl_q != '0) begin
          pop     = 1'b1;
          state_d = S_LOAD;
        end
        S_LOAD: begin
          if (cur_q <= 5'd25)      state_d = S_MARK;
          else if (cur_q == 5'd26) state_d = S_WORD_GAP;
          else                     state_d = S_IDLE;
        end
        S_MARK: if (tmr_q == (dash ? T_DASH : T_DOT))
          state_d = (({1'b0, el_q} + 3'd1) < len_q) ? S_EL_GAP : S_CHAR_GAP;
        S_EL_GAP: if (tmr_q == T_DOT) state_d = S_MARK;
        S_CHAR_GAP: if (tmr_q == T_CG) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
        S_WORD_GAP: if (tmr_q == T_WG) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
    tmr_d = (state_d != state_q || state_q == S_IDLE) ? '0 : tmr_q + TW'(1);
    led_d = (state_q == S_MARK) && iEnable && !iClear;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      cur_q   <= '0;
      len_q   <= '0;
      pat_q   <= '0;
      el_q    <= '0;
      led_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      led_q   <= led_d;
      done_q  <= done_d;
      if (pop) begin
        cur_q          <= head;
        {len_q, pat_q} <= morse_lut(head);
        el_q           <= '0;
      end else if (state_d == S_IDLE) begin
        cur_q <= '0;
      end
      if (state_q == S_EL_GAP && state_d == S_MARK) el_q <= el_q + 2'd1;
    end
  end

  assign oLED      = led_q;
  assign oCharDone = done_q;
  assign oBusy     = (state_q != S_IDLE);
  assign oCurChar  = cur_q;

endmodule
